// File: rtl/cbx_param_cfg.sv
// cbx_param_cfg: parametrised X-direction connection block.
// W horizontal tracks pass straight through in both directions. Each of the
// N_IPIN grid input pins is a full crossbar mux over all 2*W tracks. The mux
// selects sit in a double-buffered store: shadow words are written through
// the programming port, copied to the active set atomically on commit, and
// the active words can be read back.
// Select code s < 2*W picks left track s/2 (s even) or right track s/2
// (s odd). Any larger code, including the all-ones reset value, leaves the
// pin disconnected and driving 0.
module cbx_param_cfg #(
  parameter int W       = 9,
  parameter int N_IPIN  = 6,
  parameter int SEL_W   = $clog2(2*W+1),
  parameter int ADDR_W  = $clog2(N_IPIN),
  parameter int OUT_REG = 0
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic [W-1:0]      chanx_left_in,
  input  logic [W-1:0]      chanx_right_in,
  output logic [W-1:0]      chanx_left_out,
  output logic [W-1:0]      chanx_right_out,
  input  logic              enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [SEL_W-1:0]  data_in,
  input  logic              commit,
  input  logic              rd_en,
  output logic [SEL_W-1:0]  data_out,
  output logic              data_out_valid,
  output logic [N_IPIN-1:0] ipin_out,
  output logic              cfg_err
);

  // One extra bit so that N_IPIN itself is representable when it is a power of two.
  localparam logic [ADDR_W:0]  N_IPIN_C = (ADDR_W+1)'(N_IPIN);
  localparam logic [SEL_W-1:0] SEL_OFF  = {SEL_W{1'b1}};

  logic [SEL_W-1:0]  shadow_r [N_IPIN];
  logic [SEL_W-1:0]  active_r [N_IPIN];
  logic [SEL_W-1:0]  rd_word_s;
  logic [SEL_W-1:0]  data_out_r;
  logic              data_out_valid_r;
  logic              cfg_err_r;
  logic              addr_ok_s;
  logic [N_IPIN-1:0] ipin_dec_s;

  // Crossbar for one pin. Unmatched codes fall through to 0 (disconnected).
  function automatic logic mux_pick(input logic [SEL_W-1:0] sel,
                                    input logic [W-1:0]     left_trk,
                                    input logic [W-1:0]     right_trk);
    logic res;
    res = 1'b0;
    for (int t = 0; t < W; t++) begin
      if (sel == SEL_W'(2*t)) begin
        res = left_trk[t];
      end else if (sel == SEL_W'(2*t+1)) begin
        res = right_trk[t];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign chanx_right_out = chanx_left_in;
  assign chanx_left_out  = chanx_right_in;
  assign addr_ok_s       = ({1'b0, address} < N_IPIN_C);
  assign data_out        = data_out_r;
  assign data_out_valid  = data_out_valid_r;
  assign cfg_err         = cfg_err_r;

  // Decode every pin from the active selects and the current track values.
  always_comb begin
    ipin_dec_s = {N_IPIN{1'b0}};
    for (int k = 0; k < N_IPIN; k++) begin
      ipin_dec_s[k] = mux_pick(active_r[k], chanx_left_in, chanx_right_in);
    end
  end

  // Readback word selection. An out-of-range address matches no entry and reads 0.
  always_comb begin
    rd_word_s = {SEL_W{1'b0}};
    for (int k = 0; k < N_IPIN; k++) begin
      if (address == ADDR_W'(k)) begin
        rd_word_s = active_r[k];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
  end

  // Shadow writes and atomic commit. Commit copies the pre-edge shadow, so a
  // write in the same cycle reaches the active set only on a later commit.
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      for (int k = 0; k < N_IPIN; k++) begin
        shadow_r[k] <= SEL_OFF;
        active_r[k] <= SEL_OFF;
      end
    end else begin
      for (int k = 0; k < N_IPIN; k++) begin
        if (commit) begin
          active_r[k] <= shadow_r[k];
        end
        if (enable && addr_ok_s && (address == ADDR_W'(k))) begin
          shadow_r[k] <= data_in;
        end
      end
    end
  end

  // Readback port with one cycle of latency, plus the sticky bad-address flag.
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      data_out_r       <= {SEL_W{1'b0}};
      data_out_valid_r <= 1'b0;
      cfg_err_r        <= 1'b0;
    end else begin
      if (rd_en) begin
        data_out_r       <= rd_word_s;
        data_out_valid_r <= 1'b1;
      end else begin
        data_out_valid_r <= 1'b0;
      end
      if ((enable || rd_en) && !addr_ok_s) begin
        cfg_err_r <= 1'b1;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [N_IPIN-1:0] ipin_r;
      // Registered pin outputs: one prog_clk of latency after the decode.
      always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
          ipin_r <= {N_IPIN{1'b0}};
        end else begin
          ipin_r <= ipin_dec_s;
        end
      end
      assign ipin_out = ipin_r;
    end else begin : g_out_comb
      assign ipin_out = ipin_dec_s;
    end
  endgenerate

endmodule

// File: tb/tb_cbx_param_cfg.sv
// Self-checking bench for cbx_param_cfg. Two instances share the stimulus:
// dut0 with combinational pin outputs, dut1 with registered pin outputs.
// A behavioural model (select arrays plus arithmetic decode) supplies the
// expected values for the randomized phase.
module tb_cbx_param_cfg;
  localparam int W  = 9;
  localparam int N  = 6;
  localparam int SW = 5;
  localparam int AW = 3;
  localparam logic [SW-1:0] ALL1 = 5'h1f;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  l_in = 9'h000, r_in = 9'h000;
  logic          en = 1'b0, cmt = 1'b0, rd = 1'b0;
  logic [AW-1:0] addr = 3'd0;
  logic [SW-1:0] din = 5'd0;

  logic [W-1:0]  lo0, ro0, lo1, ro1;
  logic [SW-1:0] do0, do1;
  logic          dv0, dv1, err0, err1;
  logic [N-1:0]  ip0, ip1;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [SW-1:0] m_sh [N];
  logic [SW-1:0] m_ac [N];
  logic [SW-1:0] m_do = 5'd0;
  logic          m_dv = 1'b0, m_err = 1'b0;
  logic [N-1:0]  m_ipr = 6'd0;

  always #5 clk = ~clk;

  cbx_param_cfg #(.W(W), .N_IPIN(N), .OUT_REG(0)) dut0 (
    .prog_clk(clk), .pReset_n(rst_n), .chanx_left_in(l_in), .chanx_right_in(r_in),
    .chanx_left_out(lo0), .chanx_right_out(ro0), .enable(en), .address(addr),
    .data_in(din), .commit(cmt), .rd_en(rd), .data_out(do0), .data_out_valid(dv0),
    .ipin_out(ip0), .cfg_err(err0));

  cbx_param_cfg #(.W(W), .N_IPIN(N), .OUT_REG(1)) dut1 (
    .prog_clk(clk), .pReset_n(rst_n), .chanx_left_in(l_in), .chanx_right_in(r_in),
    .chanx_left_out(lo1), .chanx_right_out(ro1), .enable(en), .address(addr),
    .data_in(din), .commit(cmt), .rd_en(rd), .data_out(do1), .data_out_valid(dv1),
    .ipin_out(ip1), .cfg_err(err1));

  // Expected pins from the model's active selects: even code -> left[s/2],
  // odd code -> right[s/2], code >= 2W -> 0.
  function automatic logic [N-1:0] ref_ipin(input logic [W-1:0] l, input logic [W-1:0] r);
    logic [N-1:0] v;
    int s;
    v = '0;
    for (int k = 0; k < N; k++) begin
      s = int'(m_ac[k]);
      if (s < 2*W) v[k] = (s % 2 == 0) ? l[s/2] : r[s/2];
      else v[k] = 1'b0;
    end
    return v;
  endfunction

  // Advance one clock: compute model next state from pre-edge inputs, then apply it.
  task automatic tick();
    logic [SW-1:0] nsh [N];
    logic [SW-1:0] nac [N];
    logic [SW-1:0] ndo;
    logic ndv, nerr;
    logic [N-1:0] nip;
    nsh = m_sh; nac = m_ac; ndo = m_do; ndv = m_dv; nerr = m_err; nip = m_ipr;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin nsh[k] = ALL1; nac[k] = ALL1; end
      ndo = '0; ndv = 1'b0; nerr = 1'b0; nip = '0;
    end else begin
      nip = ref_ipin(l_in, r_in);
      if (cmt) nac = m_sh;
      if (en && int'(addr) < N) nsh[addr] = din;
      if (rd) begin
        ndv = 1'b1;
        ndo = (int'(addr) < N) ? m_ac[addr] : 5'd0;
      end else ndv = 1'b0;
      if ((en || rd) && int'(addr) >= N) nerr = 1'b1;
    end
    @(posedge clk);
    m_sh = nsh; m_ac = nac; m_do = ndo; m_dv = ndv; m_err = nerr; m_ipr = nip;
    #1;
  endtask

  task automatic idle();
    en = 1'b0; cmt = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); en = 1'b1; cmt = 1'b1; rd = 1'b1; addr = 3'd1; din = 5'd2;
    l_in = 9'h1a5; r_in = 9'h05a;
    tick();
    n_tests++; if (ip0 !== 6'd0) begin n_fail++; $display("FAIL reset_ip0: got %h want 00", ip0); end
    n_tests++; if (ip1 !== 6'd0) begin n_fail++; $display("FAIL reset_ip1: got %h want 00", ip1); end
    n_tests++; if ({do0, dv0, err0} !== 7'd0) begin n_fail++; $display("FAIL reset_rd: got do=%h dv=%b err=%b want 0", do0, dv0, err0); end
    n_tests++; if (ro0 !== 9'h1a5 || lo0 !== 9'h05a) begin n_fail++; $display("FAIL reset_pass: got ro=%h lo=%h want 1a5/05a", ro0, lo0); end
    rst_n = 1'b1; idle(); cmt = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      l_in = W'($urandom); r_in = W'($urandom); #1;
      n_tests++; if (ip0 !== 6'd0) begin n_fail++; $display("FAIL empty_commit_ip0: got %h want 00", ip0); end
    end
    rd = 1'b1; addr = 3'd3;
    tick();
    idle();
    n_tests++; if (do0 !== ALL1 || dv0 !== 1'b1) begin n_fail++; $display("FAIL empty_rd3: got %h/%b want 1f/1", do0, dv0); end
    n_tests++; if (ip1 !== 6'd0) begin n_fail++; $display("FAIL empty_ip1: got %h want 00", ip1); end
  endtask

  task automatic test_mux_decode();
    en = 1'b1; addr = 3'd0; din = 5'd0;  tick();
    addr = 3'd1; din = 5'd3;              tick();
    addr = 3'd5; din = 5'd16;             tick();
    idle(); cmt = 1'b1;                   tick();
    idle(); l_in = 9'h001; r_in = 9'h002; #1;
    n_tests++; if (ip0[0] !== 1'b1 || ip0[1] !== 1'b1 || ip0[5] !== 1'b0) begin n_fail++; $display("FAIL mux_basic: got %h want bits0,1=1 bit5=0", ip0); end
    l_in[8] = 1'b1; #1;
    n_tests++; if (ip0[5] !== 1'b1) begin n_fail++; $display("FAIL mux_l8: got %b want 1", ip0[5]); end
    n_tests++; if (ip0 !== ref_ipin(l_in, r_in)) begin n_fail++; $display("FAIL mux_model: got %h want %h", ip0, ref_ipin(l_in, r_in)); end
    tick();
    n_tests++; if (ip1[5] !== 1'b1) begin n_fail++; $display("FAIL mux_l8_reg: got %b want 1", ip1[5]); end
  endtask

  task automatic test_shadow_no_commit();
    en = 1'b1; addr = 3'd2; din = 5'd4; tick();
    idle(); l_in = 9'h1ff; #1;
    n_tests++; if (ip0[2] !== 1'b0) begin n_fail++; $display("FAIL shadow_only_ip2: got %b want 0", ip0[2]); end
    rd = 1'b1; tick(); idle();
    n_tests++; if (do0 !== ALL1 || dv0 !== 1'b1) begin n_fail++; $display("FAIL shadow_only_rd: got %h/%b want 1f/1", do0, dv0); end
    cmt = 1'b1; tick(); idle();
    for (int i = 0; i < 4; i++) begin
      l_in = W'($urandom); #1;
      n_tests++; if (ip0[2] !== l_in[2]) begin n_fail++; $display("FAIL commit_ip2: got %b want %b", ip0[2], l_in[2]); end
    end
  endtask

  task automatic test_write_commit_same();
    en = 1'b1; addr = 3'd0; din = 5'd0; tick();
    din = 5'd7; cmt = 1'b1; tick(); idle();
    rd = 1'b1; addr = 3'd0; tick(); idle();
    n_tests++; if (do0 !== 5'd0) begin n_fail++; $display("FAIL wc_first: got %h want 00", do0); end
    cmt = 1'b1; tick(); idle();
    rd = 1'b1; tick(); idle();
    n_tests++; if (do0 !== 5'd7) begin n_fail++; $display("FAIL wc_second: got %h want 07", do0); end
    // read in the commit cycle returns the pre-commit word
    en = 1'b1; din = 5'd9; tick(); idle();
    rd = 1'b1; cmt = 1'b1; tick(); idle();
    n_tests++; if (do0 !== 5'd7) begin n_fail++; $display("FAIL rd_commit_same: got %h want 07", do0); end
  endtask

  task automatic test_out_of_range();
    en = 1'b1; addr = 3'd6; din = 5'd2; tick(); idle();
    n_tests++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", err0); end
    cmt = 1'b1; tick(); idle();
    for (int k = 0; k < N; k++) begin
      rd = 1'b1; addr = AW'(k); tick(); idle();
      n_tests++; if (do0 !== m_ac[k]) begin n_fail++; $display("FAIL oor_store%0d: got %h want %h", k, do0, m_ac[k]); end
    end
    rd = 1'b1; addr = 3'd7; tick(); idle();
    n_tests++; if (do0 !== 5'd0 || dv0 !== 1'b1) begin n_fail++; $display("FAIL oor_rd7: got %h/%b want 00/1", do0, dv0); end
    tick(); tick();
    n_tests++; if (err0 !== 1'b1 || dv0 !== 1'b0 || do0 !== 5'd0) begin n_fail++; $display("FAIL oor_sticky: got err=%b dv=%b do=%h want 1/0/00", err0, dv0, do0); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL oor_reset: got %b want 0", err0); end
  endtask

  task automatic test_out_reg();
    l_in = 9'h000; r_in = 9'h000;
    en = 1'b1; addr = 3'd0; din = 5'd1; tick();
    idle(); cmt = 1'b1; tick(); idle(); tick();
    n_tests++; if (ip1[0] !== 1'b0) begin n_fail++; $display("FAIL oreg_idle: got %b want 0", ip1[0]); end
    r_in[0] = 1'b1; #1;
    n_tests++; if (ip0[0] !== 1'b1 || ip1[0] !== 1'b0) begin n_fail++; $display("FAIL oreg_pre: got comb=%b reg=%b want 1/0", ip0[0], ip1[0]); end
    tick(); r_in[0] = 1'b0;
    n_tests++; if (ip1[0] !== 1'b1) begin n_fail++; $display("FAIL oreg_edge: got %b want 1", ip1[0]); end
    tick();
    n_tests++; if (ip1[0] !== 1'b0) begin n_fail++; $display("FAIL oreg_fall: got %b want 0", ip1[0]); end
    r_in[0] = 1'b1; en = 1'b1; addr = 3'd0; din = 5'd5; tick();
    idle(); rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_tests++; if (ip1 !== 6'd0 || ip0 !== 6'd0) begin n_fail++; $display("FAIL oreg_reset: got reg=%h comb=%h want 00/00", ip1, ip0); end
    cmt = 1'b1; tick(); idle();
    rd = 1'b1; addr = 3'd0; tick(); idle();
    n_tests++; if (do0 !== ALL1) begin n_fail++; $display("FAIL oreg_shadow_cleared: got %h want 1f", do0); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      en    = ($urandom_range(0, 2) == 0);
      cmt   = ($urandom_range(0, 4) == 0);
      rd    = ($urandom_range(0, 1) == 0);
      addr  = AW'($urandom_range(0, 7));
      din   = SW'($urandom_range(0, 31));
      l_in  = W'($urandom);
      r_in  = W'($urandom);
      #1;
      n_tests++; if (ip0 !== ref_ipin(l_in, r_in)) begin n_fail++; $display("FAIL rnd_ip0 c%0d: got %h want %h", c, ip0, ref_ipin(l_in, r_in)); end
      n_tests++; if (ro1 !== l_in || lo1 !== r_in) begin n_fail++; $display("FAIL rnd_pass c%0d: got %h/%h want %h/%h", c, ro1, lo1, l_in, r_in); end
      tick();
      n_tests++; if (ip1 !== m_ipr) begin n_fail++; $display("FAIL rnd_ip1 c%0d: got %h want %h", c, ip1, m_ipr); end
      n_tests++; if (do0 !== m_do || dv0 !== m_dv) begin n_fail++; $display("FAIL rnd_rd c%0d: got %h/%b want %h/%b", c, do0, dv0, m_do, m_dv); end
      n_tests++; if (err0 !== m_err || err1 !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b/%b want %b", c, err0, err1, m_err); end
    end
    rst_n = 1'b1; idle();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin m_sh[k] = ALL1; m_ac[k] = ALL1; end
    test_reset();
    test_mux_decode();
    test_shadow_no_commit();
    test_write_commit_same();
    test_out_of_range();
    test_out_reg();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cbx_param_cfg.md
Name: cbx_param_cfg

Overview:
- Parametrised X-direction connection block: next generation of the fixed-width, decoder-programmed CBX tile.
- Passes W horizontal tracks straight through in both directions.
- Drives N_IPIN grid input pins, each through a full-crossbar mux over all 2*W tracks.
- Mux selects are held in a double-buffered configuration store: shadow words written via the enable/address/data_in programming port, copied atomically to the active set on commit, and readable back.

Parameters:
- W, 9, tracks per direction (chanx_left_in / chanx_right_in width).
- N_IPIN, 6, number of grid input pins (muxes).
- SEL_W, $clog2(2*W+1), select word width; codes >= 2*W mean "disconnected".
- ADDR_W, $clog2(N_IPIN), programming address width.
- OUT_REG, 0, 1 = register ipin outputs (one prog_clk of latency); 0 = combinational.

Ports:
- prog_clk  input  1  configuration/system clock, rising edge.
- pReset_n  input  1  synchronous active-low reset.
- chanx_left_in  input  W  tracks entering from the left.
- chanx_right_in  input  W  tracks entering from the right.
- chanx_left_out  output  W  tracks leaving to the left.
- chanx_right_out  output  W  tracks leaving to the right.
- enable  input  1  write strobe for shadow store.
- address  input  ADDR_W  mux index for write/read.
- data_in  input  SEL_W  select word to write.
- commit  input  1  copy shadow store to active store.
- rd_en  input  1  readback request.
- data_out  output  SEL_W  readback data (active word).
- data_out_valid  output  1  data_out qualifier.
- ipin_out  output  N_IPIN  grid input pins; bit k is mux k.
- cfg_err  output  1  sticky out-of-range address flag.

Behaviour:
- Clock and reset: one clock, prog_clk; pReset_n is synchronous and active-low, sampled only on the rising edge.
- Pass-through (combinational, independent of reset/config):
  - chanx_right_out[i] = chanx_left_in[i].
  - chanx_left_out[i] = chanx_right_in[i].
- Mux k decode, with active select s:
  - s < 2*W, s even: output chanx_left_in[s/2].
  - s < 2*W, s odd: output chanx_right_in[s/2].
  - s >= 2*W: output 0.
  - OUT_REG=0: ipin_out[k] follows inputs and active store combinationally.
  - OUT_REG=1: ipin_out[k] is the decoded value registered on prog_clk.
- Reset (pReset_n=0 at edge):
  - All shadow and active words set to all-ones (disconnected).
  - ipin_out = 0 (register or decode), data_out = 0, data_out_valid = 0, cfg_err = 0.
  - Reset overrides enable/commit/rd_en in the same cycle.
  - Reset mid-programming discards all partially written shadow words.
- Write: enable=1 and address < N_IPIN sets shadow[address] <= data_in at the edge. Active store and outputs are unchanged.
- Commit: commit=1 sets active[k] <= shadow[k] for all k, using pre-edge shadow values.
  - Write and commit in the same cycle: the write lands in shadow only; active receives the old shadow word for that address.
- Readback: rd_en=1 gives data_out <= active[address] and data_out_valid <= 1 at the next edge (1-cycle latency).
  - rd_en=0 gives data_out_valid <= 0; data_out holds its last value.
  - Read in the same cycle as commit returns the pre-commit active value.
  - Read and write in the same cycle are both performed.
- Out-of-range address (address >= N_IPIN) with enable or rd_en:
  - Write is ignored.
  - Read returns data_out = 0 with data_out_valid = 1.
  - cfg_err <= 1, and stays set until reset.
- Back-to-back writes/reads/commits every cycle are legal; there is no busy state.

Test Plan:
- Reset, then commit with no writes: every ipin_out = 0 for any track pattern; readback of address 3 gives data_out = 2^SEL_W-1 with valid = 1 one cycle later.
- W=9: write shadow[0]=0, shadow[1]=3, shadow[5]=16, then commit. Drive chanx_left_in = 9'h001, chanx_right_in = 9'h002 → ipin_out[0] = 1, ipin_out[1] = 1, ipin_out[5] = 0. Toggle chanx_left_in[8] → ipin_out[5] = 1.
- Write shadow[2]=4 without commit → ipin_out[2] stays 0 and readback returns all-ones. Assert commit → ipin_out[2] tracks chanx_left_in[2] from the next edge (OUT_REG=0).
- Same-cycle write shadow[0]=7 and commit, after a prior shadow[0]=0 → active[0] = 0; a second commit → active[0] = 7.
- Write to address 6 (N_IPIN = 6) → no store changes, cfg_err = 1 and sticky; read of address 7 → data_out = 0, valid = 1. Reset → cfg_err = 0.
- OUT_REG=1: after configuring mux 0 to code 1, a pulse on chanx_right_in[0] appears on ipin_out[0] exactly one prog_clk later. Reset asserted mid-sequence → ipin_out = 0 at that edge and shadow[0] = all-ones.
